// File: rtl/if_stage_prefetch_if.sv
// Instruction-memory request/response port used by the fetch stage.
// The master issues requests; the slave (cache or memory) grants them and returns data in order.
interface if_stage_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a single-outstanding request port and a DEPTH-entry prefetch queue.
// A taken branch flushes the queue and drops any in-flight response.
module if_stage_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 mem_freeze,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_addr,
  if_stage_prefetch_if.master  imem,
  output logic                 inst_valid,
  output logic [ADDR_W-1:0]    PC,
  output logic [INST_W-1:0]    instruction
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic grant, push, pop;
  logic [ADDR_W-1:0] head_addr;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid)  state_d = S_IDLE;
        else if (branch_taken) state_d = S_DROP;
      end
      S_DROP: if (imem.imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; a request is withheld during reset and in a branch cycle
  always_comb begin
    imem.imem_req = 1'b0;
    if (state_q == S_IDLE && !rst && !branch_taken && count_q < CNT_W'(DEPTH))
      imem.imem_req = 1'b1;
  end

  assign imem.imem_addr = fetch_pc_q;
  assign grant = imem.imem_req & imem.imem_gnt;

  assign inst_valid = (count_q != '0);
  assign push = (state_q == S_WAIT) && imem.imem_rvalid && !branch_taken;
  assign pop  = inst_valid && !freeze && !mem_freeze && !branch_taken;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (grant) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every register samples pre-edge values.
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= req_pc_q;
      inst_mem_q[wr_ptr_q] <= imem.imem_rdata;
    end
  end

  // With an empty queue the PC output tracks the next fetch address
  assign head_addr   = inst_valid ? addr_mem_q[rd_ptr_q] : fetch_pc_q;
  assign PC          = head_addr + STEP;
  assign instruction = inst_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch: bench-side memory model returns rdata = addr << 4
// a programmable number of cycles after each grant.
module tb_if_stage_prefetch;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, mem_freeze, branch_taken;
  logic [31:0] branch_addr;
  logic        inst_valid;
  logic [31:0] PC, instruction;

  int checks, errors;
  int lat, left, ngrant;
  bit pend;
  logic [31:0] paddr;

  if_stage_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_stage_prefetch #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .PC_STEP(1),
    .RESET_PC(32'h0), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .mem_freeze(mem_freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem(bus), .inst_valid(inst_valid), .PC(PC), .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; also advances the memory model
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = bus.imem_req & bus.imem_gnt;
    a = bus.imem_addr;
    @(posedge clk);
    #1;
    if (bus.imem_rvalid) begin
      bus.imem_rvalid = 1'b0;
      pend = 1'b0;
    end
    if (g) begin
      pend = 1'b1;
      left = lat;
      paddr = a;
      ngrant++;
    end
    if (pend) begin
      left--;
      if (left == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = paddr << 4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; mem_freeze = 1'b0;
    branch_taken = 1'b0; branch_addr = '0;
    bus.imem_rvalid = 1'b0; pend = 1'b0; lat = 1;
    tick(); tick();
    rst = 1'b0; ngrant = 0;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; ngrant = 0; pend = 1'b0; left = 0; lat = 1; paddr = '0;
    rst = 1'b1; freeze = 1'b0; mem_freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", instruction, NOP);
    check("rst_pc", PC, 32'd1);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 32'd0);

    // Free-running fetch, 1-cycle memory
    rst = 1'b0; ngrant = 0; #1;
    check("t1_req0", bus.imem_req, 1'b1);
    check("t1_addr0", bus.imem_addr, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t1_gap", inst_valid, 1'b0);
      tick();
      check("t1_valid", inst_valid, 1'b1);
      check("t1_pc", PC, 32'(k + 1));
      check("t1_inst", instruction, 32'(k * 16));
      check("t1_addr", bus.imem_addr, 32'(k + 1));
      tick();
    end
    check("t1_ngrant", 32'(ngrant), 32'd5);

    // Hazard freeze fills the queue, then drains in order
    do_reset();
    freeze = 1'b1; #1;
    repeat (8) tick();
    check("t2_full_req", bus.imem_req, 1'b0);
    check("t2_ngrant", 32'(ngrant), 32'd4);
    check("t2_pc", PC, 32'd1);
    check("t2_inst", instruction, 32'h0);
    repeat (2) tick();
    check("t2_hold_req", bus.imem_req, 1'b0);
    check("t2_hold_ngrant", 32'(ngrant), 32'd4);
    freeze = 1'b0; #1;
    check("t2_pc_c10", PC, 32'd1);
    tick();
    check("t2_req_c11", bus.imem_req, 1'b1);
    check("t2_addr_c11", bus.imem_addr, 32'd4);
    check("t2_pc_c11", PC, 32'd2);
    check("t2_inst_c11", instruction, 32'h10);
    tick();
    check("t2_pc_c12", PC, 32'd3);
    check("t2_inst_c12", instruction, 32'h20);
    tick();
    check("t2_pc_c13", PC, 32'd4);
    check("t2_inst_c13", instruction, 32'h30);
    check("t2_addr_c13", bus.imem_addr, 32'd5);
    tick();
    check("t2_pc_c14", PC, 32'd5);
    check("t2_inst_c14", instruction, 32'h40);
    tick();
    check("t2_pc_c15", PC, 32'd6);
    check("t2_inst_c15", instruction, 32'h50);

    // Branch while the addr-5 request is in flight
    do_reset();
    repeat (10) tick();
    lat = 3;
    check("t3_addr5", bus.imem_addr, 32'd5);
    check("t3_pc5", PC, 32'd5);
    tick();
    check("t3_wait_valid", inst_valid, 1'b0);
    branch_taken = 1'b1; branch_addr = 32'd36; #1;
    check("t3_br_req", bus.imem_req, 1'b0);
    tick();
    branch_taken = 1'b0; #1;
    check("t3_drop_req", bus.imem_req, 1'b0);
    check("t3_drop_valid", inst_valid, 1'b0);
    tick();
    check("t3_resp_valid", inst_valid, 1'b0);
    check("t3_resp_req", bus.imem_req, 1'b0);
    lat = 1;
    tick();
    check("t3_req36", bus.imem_req, 1'b1);
    check("t3_addr36", bus.imem_addr, 32'd36);
    check("t3_idle_valid", inst_valid, 1'b0);
    tick();
    check("t3_wait36_valid", inst_valid, 1'b0);
    tick();
    check("t3_valid37", inst_valid, 1'b1);
    check("t3_pc37", PC, 32'd37);
    check("t3_inst37", instruction, 32'h240);

    // Branch coincident with a response; then branch with a full-ish queue under freeze
    do_reset();
    tick();
    branch_taken = 1'b1; branch_addr = 32'd10; #1;
    check("t4_br_req", bus.imem_req, 1'b0);
    tick();
    branch_taken = 1'b0; #1;
    check("t4_valid", inst_valid, 1'b0);
    check("t4_req10", bus.imem_req, 1'b1);
    check("t4_addr10", bus.imem_addr, 32'd10);
    tick();
    check("t4_wait_valid", inst_valid, 1'b0);
    tick();
    check("t4_valid11", inst_valid, 1'b1);
    check("t4_pc11", PC, 32'd11);
    check("t4_inst11", instruction, 32'hA0);
    check("t4_addr11", bus.imem_addr, 32'd11);
    branch_taken = 1'b1; branch_addr = 32'd100; freeze = 1'b1; #1;
    check("t4_br2_req", bus.imem_req, 1'b0);
    tick();
    branch_taken = 1'b0; freeze = 1'b0; #1;
    check("t4_flush_valid", inst_valid, 1'b0);
    check("t4_req100", bus.imem_req, 1'b1);
    check("t4_addr100", bus.imem_addr, 32'd100);

    // Memory freeze holds the head while the queue fills
    do_reset();
    tick(); tick();
    mem_freeze = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check("t5_valid", inst_valid, 1'b1);
      check("t5_pc", PC, 32'd1);
      check("t5_inst", instruction, 32'h0);
      tick();
    end
    tick();
    check("t5_full_req", bus.imem_req, 1'b0);
    check("t5_ngrant", 32'(ngrant), 32'd4);
    check("t5_pc_full", PC, 32'd1);
    mem_freeze = 1'b0; #1;
    tick();
    check("t5_req4", bus.imem_req, 1'b1);
    check("t5_addr4", bus.imem_addr, 32'd4);
    check("t5_pc2", PC, 32'd2);
    check("t5_inst2", instruction, 32'h10);

    // Reset in WAIT; stale response arrives the cycle after reset
    do_reset();
    lat = 2;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("t6_valid", inst_valid, 1'b0);
    check("t6_inst", instruction, NOP);
    check("t6_req", bus.imem_req, 1'b1);
    check("t6_addr", bus.imem_addr, 32'd0);
    lat = 1;
    tick();
    check("t6_stale_valid", inst_valid, 1'b0);
    tick();
    check("t6_valid1", inst_valid, 1'b1);
    check("t6_pc1", PC, 32'd1);
    check("t6_inst0", instruction, 32'h0);
    tick();
    check("t6_single", inst_valid, 1'b0);

    // Address wrap at the top of the address space
    do_reset();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF; #1;
    check("t7_br_req", bus.imem_req, 1'b0);
    tick();
    branch_taken = 1'b0; #1;
    check("t7_addr_top", bus.imem_addr, 32'hFFFF_FFFF);
    tick(); tick();
    check("t7_valid", inst_valid, 1'b1);
    check("t7_pc_wrap", PC, 32'h0);
    check("t7_inst", instruction, 32'hFFFF_FFF0);
    check("t7_addr_wrap", bus.imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
